pwm_duty_decoder: RTL
=====================

Name: pwm_duty_decoder

Overview:
- Receive side of the LED PWM drive: measures the per-channel duty cycle of free-running 8-bit PWM LED signals and reports the recovered brightness codes.
- Each measurement window is a fixed 2^PERIOD_BITS-cycle frame. Any full window of a periodic PWM gives the exact high-time, so no phase alignment with the source is needed.
- Used for loopback self-test of the LED driver and to monitor remote LED state.

Parameters:
- CHANNELS, 8, number of PWM inputs decoded in parallel.
- PERIOD_BITS, 8, log2 of the PWM/frame period in clock cycles (frame = 256 cycles).
- STABLE_FRAMES, 4, number of consecutive unchanged frames before `stable` asserts (1..255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pwm_in  input  CHANNELS  PWM inputs; may be asynchronous to clk.
- duty_flat  output  CHANNELS*(PERIOD_BITS+1)  last measured high-cycle count per channel. Channel i occupies bits [i*(PERIOD_BITS+1) +: PERIOD_BITS+1]. Range 0..2^PERIOD_BITS.
- sample_valid  output  1  one-cycle pulse; duty_flat and changed_mask updated this cycle.
- changed_mask  output  CHANNELS  bit i = channel i duty differs from its previous value; meaningful while sample_valid is high, held otherwise.
- stable  output  1  high after STABLE_FRAMES consecutive frames with changed_mask == 0.

Behaviour:
- Reset (async assert, sync release):
  - duty_flat=0, sample_valid=0, changed_mask=0, stable=0.
  - Internal frame counter, high counters, stable counter and synchronizers = 0. State = WARMUP.
- Input sync: 2-flop synchronizer per channel. Sampled bit s[i] lags pwm_in by 2 cycles.
- Frame counter: PERIOD_BITS wide, free-running, +1 every cycle, wraps from 2^PERIOD_BITS-1 to 0. First post-reset edge takes it 0->1.
- High counters: PERIOD_BITS+1 bits each. Every cycle hi[i] += s[i].
- Frame end (frame counter == 2^PERIOD_BITS-1):
  - End value = hi[i]+s[i]. hi[i] <= 0.
  - A window is therefore exactly 2^PERIOD_BITS samples. All-high gives 2^PERIOD_BITS (9'h100), which must not wrap to 0.
- FSM:
  - WARMUP: the first frame end after reset discards its result (the synchronizer held reset values). No duty update, no valid pulse. Go to MEASURE.
  - MEASURE: at every frame end, on the next edge:
    - duty[i] <= end value;
    - changed_mask[i] <= (end value != old duty[i]);
    - sample_valid <= 1 for exactly one cycle.
    - The first MEASURE frame compares against reset duty 0.
- Stable counter (8-bit), updated on the sample_valid edge:
  - If any changed bit is set: counter <= 0, stable <= 0.
  - Otherwise: counter increments, saturating at STABLE_FRAMES. stable <= 1 once counter reaches STABLE_FRAMES.
- Timing:
  - First sample_valid is high in the cycle after the 512th rising edge following reset release (PERIOD_BITS=8).
  - sample_valid then repeats every 256 cycles; it is never high on two consecutive cycles.
- Mid-window duty change: that frame may report an intermediate value, so changed_mask can set in two consecutive frames. This is legal behaviour.
- Reset mid-operation: all outputs return to reset values immediately. Warmup restarts.
- No overflow is possible: hi counter max = 2^PERIOD_BITS fits in PERIOD_BITS+1 bits.

Test Plan:
- Reset release with pwm_in=8'hFF held:
  - first sample_valid exactly 512 cycles after release;
  - every duty = 256; changed_mask = 8'hFF;
  - stable=1 after 4 further valid pulses with no change.
- Ch0 all-low, ch1 PWM with brightness 96, ch2 brightness 1, ch7 brightness 224; source counter at arbitrary phase offset (e.g. 37):
  - duties 0/96/1/224 from the second valid frame onward, independent of offset.
- Steady inputs, then ch3 brightness steps 32 -> 64 mid-frame:
  - changed_mask bit3 set (8'h08) in one or two frames;
  - final duty ch3 = 64;
  - stable drops to 0, then reasserts after 4 unchanged frames.
- pwm_in toggling every cycle on ch5 → duty ch5 = 128 every frame; changed_mask stays 0 after the first compare.
- rst_n pulsed low for 3 cycles mid-frame while duties are nonzero:
  - outputs go to 0 asynchronously;
  - no sample_valid for 512 cycles after release, then correct duties.
- Random per-channel brightness 0..255 held for 10 frames each, checked against a scoreboard → exact match every frame after settling.

Source files
------------

// File: rtl/pwm_duty_decoder.sv
// Recovers per-channel PWM duty (high cycles per 2^PERIOD_BITS frame) and flags changes/stability.
// Latency: 2-cycle input sync, result one edge after frame end; first valid 2 frames after reset; no backpressure.
module pwm_duty_decoder #(
  parameter int CHANNELS      = 8,
  parameter int PERIOD_BITS   = 8,
  parameter int STABLE_FRAMES = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CHANNELS-1:0]                 pwm_in,
  output logic [CHANNELS*(PERIOD_BITS+1)-1:0] duty_flat,
  output logic                                sample_valid,
  output logic [CHANNELS-1:0]                 changed_mask,
  output logic                                stable
);

  localparam int DW = PERIOD_BITS + 1;
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_FRAMES);

  typedef enum logic {WARMUP, MEASURE} state_t;

  state_t                        state_q, state_d;
  logic [CHANNELS-1:0]           sync_q1, sync_q2;
  logic [PERIOD_BITS-1:0]        frame_cnt;
  logic [CHANNELS-1:0][DW-1:0]   hi_cnt;
  logic [CHANNELS-1:0][DW-1:0]   end_val;
  logic [CHANNELS-1:0][DW-1:0]   duty_q;
  logic [CHANNELS-1:0]           chg_d;
  logic [7:0]                    stable_cnt;
  logic                          frame_end;
  logic                          meas_en;

  assign frame_end = &frame_cnt;
  assign duty_flat = duty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1   <= '0;
      sync_q2   <= '0;
      frame_cnt <= '0;
      state_q   <= WARMUP;
    end else begin
      sync_q1   <= pwm_in;
      sync_q2   <= sync_q1;
      frame_cnt <= frame_cnt + PERIOD_BITS'(1);
      state_q   <= state_d;
    end
  end

  // The closing sample is folded in so a window is exactly 2^PERIOD_BITS samples.
  always_comb begin
    end_val = '0;
    chg_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      end_val[i] = hi_cnt[i] + DW'(sync_q2[i]);
      chg_d[i]   = (end_val[i] != duty_q[i]);
    end
  end

  // The first frame after reset includes synchronizer reset values, so it is dropped.
  always_comb begin
    state_d = state_q;
    meas_en = 1'b0;
    case (state_q)
      WARMUP: begin
        if (frame_end) state_d = MEASURE;
      end
      MEASURE: begin
        meas_en = frame_end;
      end
      default: state_d = WARMUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt <= '0;
    end else if (frame_end) begin
      hi_cnt <= '0;
    end else begin
      hi_cnt <= end_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q       <= '0;
      changed_mask <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= meas_en;
      if (meas_en) begin
        duty_q       <= end_val;
        changed_mask <= chg_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      stable     <= 1'b0;
    end else if (meas_en) begin
      if (|chg_d) begin
        stable_cnt <= '0;
        stable     <= 1'b0;
      end else begin
        if (stable_cnt < STABLE_MAX) stable_cnt <= stable_cnt + 8'd1;
        if (stable_cnt >= STABLE_MAX - 8'd1) stable <= 1'b1;
      end
    end
  end

endmodule
